// File: rtl/hilo_sequencer.sv
// HI/LO multiply sequencer: multi-cycle mult/multu/madd/msub/mul ops plus single-cycle HI/LO moves.
// Latency: multiply-class ops commit MUL_LATENCY+1 cycles after acceptance; moves take effect the next cycle.
// Backpressure: Stall asserts combinationally while Busy; the requester holds its op until Stall drops.
module hilo_sequencer #(
    parameter int unsigned MUL_LATENCY = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic [5:0]  ALUOp,
    input  logic [31:0] OpA,
    input  logic [31:0] OpB,
    input  logic        Flush,
    output logic        Stall,
    output logic        Busy,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic [31:0] Result,
    output logic        ResultValid
);

    localparam logic [5:0] OP_MADD  = 6'd2;
    localparam logic [5:0] OP_MUL   = 6'd5;
    localparam logic [5:0] OP_MSUB  = 6'd8;
    localparam logic [5:0] OP_MFHI  = 6'd15;
    localparam logic [5:0] OP_MTHI  = 6'd16;
    localparam logic [5:0] OP_MFLO  = 6'd17;
    localparam logic [5:0] OP_MTLO  = 6'd18;
    localparam logic [5:0] OP_MULT  = 6'd19;
    localparam logic [5:0] OP_MULTU = 6'd20;

    localparam logic [3:0] CNT_INIT = 4'(MUL_LATENCY - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [5:0]  op_q;
    logic [31:0] a_q, b_q;
    logic        latch_en;
    logic [63:0] hilo_nxt;
    logic [31:0] res_nxt;
    logic        rv_nxt;
    logic        is_mul_class;
    logic        is_move;
    logic [63:0] prod_s;
    logic [63:0] prod_u;

    assign is_mul_class = (ALUOp == OP_MADD) || (ALUOp == OP_MUL) || (ALUOp == OP_MSUB) ||
                          (ALUOp == OP_MULT) || (ALUOp == OP_MULTU);
    assign is_move      = (ALUOp >= OP_MFHI) && (ALUOp <= OP_MTLO);

    assign Busy  = (state == BUSY);
    assign Stall = Start && (is_mul_class || is_move) && Busy;

    // Low 64 bits of the extended product equal the signed 64-bit product.
    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u = {32'h0, a_q} * {32'h0, b_q};

    // State and latency counter register.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, counter and datapath next values; flush wins over acceptance and commit.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        latch_en  = 1'b0;
        hilo_nxt  = {Hi, Lo};
        res_nxt   = Result;
        rv_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (!Flush && Start) begin
                    if (is_mul_class) begin
                        latch_en  = 1'b1;
                        cnt_nxt   = CNT_INIT;
                        state_nxt = BUSY;
                    end else begin
                        case (ALUOp)
                            OP_MTHI: hilo_nxt[63:32] = OpA;
                            OP_MTLO: hilo_nxt[31:0]  = OpA;
                            OP_MFHI: begin
                                res_nxt = Hi;
                                rv_nxt  = 1'b1;
                            end
                            OP_MFLO: begin
                                res_nxt = Lo;
                                rv_nxt  = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            BUSY: begin
                if (Flush) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    state_nxt = IDLE;
                    case (op_q)
                        OP_MULT:  hilo_nxt = prod_s;
                        OP_MULTU: hilo_nxt = prod_u;
                        OP_MADD:  hilo_nxt = {Hi, Lo} + prod_s;
                        OP_MSUB:  hilo_nxt = {Hi, Lo} - prod_s;
                        OP_MUL: begin
                            res_nxt = prod_s[31:0];
                            rv_nxt  = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch and architectural HI/LO/Result registers.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            op_q        <= 6'd0;
            a_q         <= 32'h0;
            b_q         <= 32'h0;
            Hi          <= 32'h0;
            Lo          <= 32'h0;
            Result      <= 32'h0;
            ResultValid <= 1'b0;
        end else begin
            if (latch_en) begin
                op_q <= ALUOp;
                a_q  <= OpA;
                b_q  <= OpB;
            end
            Hi          <= hilo_nxt[63:32];
            Lo          <= hilo_nxt[31:0];
            Result      <= res_nxt;
            ResultValid <= rv_nxt;
        end
    end

endmodule

// File: doc/hilo_sequencer.md
HILO_SEQUENCER -- requirements
Module: hilo_sequencer

Interface
REQ-001 Parameter MUL_LATENCY, default 4, sets the number of Busy cycles per multiply-class op; legal range 1..15.
REQ-002 Clk  in  1  single clock; all state changes on its rising edge.
REQ-003 Reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of Clk.
REQ-004 Start  in  1  requester presents an op this cycle.
REQ-005 ALUOp  in  6  controller op code: 2 madd, 5 mul, 8 msub, 15 mfhi, 16 mthi, 17 mflo, 18 mtlo, 19 mult, 20 multu.
REQ-006 OpA  in  32  rs operand.
REQ-007 OpB  in  32  rt operand.
REQ-008 Flush  in  1  aborts any in-flight multiply.
REQ-009 Stall  out  1  combinational; request not accepted, requester holds Start/ALUOp/OpA/OpB.
REQ-010 Busy  out  1  registered; a multiply-class op is in flight.
REQ-011 Hi  out  32  registered HI register.
REQ-012 Lo  out  32  registered LO register.
REQ-013 Result  out  32  registered GPR writeback data for mul, mfhi and mflo.
REQ-014 ResultValid  out  1  registered, one-cycle pulse qualifying Result.

Function
REQ-015 Multiply-class ops are 2, 5, 8, 19 and 20; move ops are 15..18; Start with any other ALUOp is ignored, never stalls, and changes no state.
REQ-016 FSM states are IDLE and BUSY; Busy = (state == BUSY).
REQ-017 IDLE with Start and a multiply-class op: latch ALUOp, OpA and OpB; load counter with MUL_LATENCY-1; go to BUSY.
REQ-018 BUSY with counter != 0: decrement the counter.
REQ-019 BUSY with counter == 0: commit and return to IDLE.
  - Commit for mult: {Hi,Lo} = signed 64-bit product.
  - Commit for multu: {Hi,Lo} = unsigned 64-bit product.
  - Commit for madd: {Hi,Lo} = {Hi,Lo} + signed product, modulo 2^64.
  - Commit for msub: {Hi,Lo} = {Hi,Lo} - signed product, modulo 2^64.
  - Commit for mul: Result = low 32 bits of the signed product; ResultValid = 1; Hi and Lo unchanged.
REQ-020 Timing: Start accepted in cycle T gives Busy=1 in cycles T+1..T+MUL_LATENCY; committed values are visible in T+MUL_LATENCY+1.
REQ-021 Move ops are single cycle and accepted only in IDLE; the effect is visible the next cycle.
  - mthi: Hi = OpA.
  - mtlo: Lo = OpA.
  - mfhi: Result = Hi, ResultValid = 1.
  - mflo: Result = Lo, ResultValid = 1.
REQ-022 Stall = Start & (multiply-class or move op) & Busy; stalled requests have no side effects.
REQ-023 An op presented in the commit cycle stalls; it is accepted the following cycle, so mfhi reads the committed value.
REQ-024 Flush in BUSY: return to IDLE next cycle; Hi, Lo and Result unchanged; no ResultValid; this holds in the commit cycle too.
REQ-025 Flush in IDLE: any Start in the same cycle is ignored; Stall = 0.
REQ-026 ResultValid is 0 in every cycle not named in REQ-019 or REQ-021.

Reset
REQ-027 Reset_n = 0 at a rising edge forces, at that edge:
  - state IDLE, counter 0, Busy 0, ResultValid 0;
  - Hi, Lo and Result all 32'h0.
REQ-028 Reset overrides Start and Flush, and aborts an in-flight op without commit.

Verification
REQ-029 mult with OpA=32'hFFFFFFFD (-3), OpB=5 -> Busy high for exactly 4 cycles, then Hi=32'hFFFFFFFF, Lo=32'hFFFFFFF1.
REQ-030 multu FFFFFFFF x 2 -> Hi=1, Lo=FFFFFFFE; then madd 3 x 4 -> Hi=2, Lo=0000000A; then msub 1 x 11 -> Hi=1, Lo=FFFFFFFF.
REQ-031 mflo presented during Busy -> Stall=1 every Busy cycle including commit; accepted the next cycle; Result=new Lo with a one-cycle ResultValid pulse.
REQ-032 mul 7 x -2 -> Result=32'hFFFFFFF2, ResultValid pulses once, Hi and Lo unchanged; mthi 32'h1234 then mfhi -> Result=32'h1234.
REQ-033 Flush in the second Busy cycle of mult -> Busy=0 the next cycle; Hi and Lo hold their prior values; no ResultValid.
REQ-034 Reset_n=0 mid-Busy -> next cycle all outputs 0 and state IDLE; a Start with an unlisted ALUOp (e.g. 21) -> no Stall and no state change.
